// File: rtl/pixel_layer_scheduler_if.sv
// -----------------------------------------------------------------------------
// pixel_layer_scheduler_if
// Bundles the pixel request channel, the shared sprite/background ROM port and
// the result channel of the pixel layer scheduler.
//   slave  : the scheduler (accepts pixels, drives the ROM, produces results)
//   master : the surrounding logic (sprite position logic, ROM, palette stage)
// Signals:
//   pix_valid/pix_ready          pixel request handshake
//   DrawX/DrawY                  screen coordinate
//   is_ball/is_duck              sprite hit flags
//   Ball_Draw_X/Y, Duck_Draw_X/Y sprite-local coordinates
//   lives                        remaining lives
//   rom_addr/rom_layer/rom_data  shared ROM port (data one cycle after address)
//   out_valid/out_ready          result handshake
//   out_idx/out_layer            winning palette index and its layer code
// -----------------------------------------------------------------------------
interface pixel_layer_scheduler_if #(
    parameter int ROM_AW = 17,
    parameter int IDX_W  = 4
);
    logic              pix_valid;
    logic              pix_ready;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              is_ball;
    logic              is_duck;
    logic [9:0]        Ball_Draw_X;
    logic [9:0]        Ball_Draw_Y;
    logic [9:0]        Duck_Draw_X;
    logic [9:0]        Duck_Draw_Y;
    logic [3:0]        lives;
    logic [ROM_AW-1:0] rom_addr;
    logic [2:0]        rom_layer;
    logic [IDX_W-1:0]  rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic [2:0]        out_layer;

    modport slave (
        input  pix_valid, DrawX, DrawY, is_ball, is_duck,
               Ball_Draw_X, Ball_Draw_Y, Duck_Draw_X, Duck_Draw_Y, lives,
               rom_data, out_ready,
        output pix_ready, rom_addr, rom_layer, out_valid, out_idx, out_layer
    );

    modport master (
        output pix_valid, DrawX, DrawY, is_ball, is_duck,
               Ball_Draw_X, Ball_Draw_Y, Duck_Draw_X, Duck_Draw_Y, lives,
               rom_data, out_ready,
        input  pix_ready, rom_addr, rom_layer, out_valid, out_idx, out_layer
    );
endinterface

// File: rtl/pixel_layer_scheduler.sv
// -----------------------------------------------------------------------------
// pixel_layer_scheduler
// Shares one synchronous ROM read port between the five display layers
// (0 LIVES, 1 SCOPE, 2 GRASS, 3 DUCK, 4 BACK). For each accepted pixel the
// layers are fetched in priority order; the first eligible layer returning a
// non-zero palette index wins, with BACK as the fallback.
// Ports:
//   Clk      system clock
//   Reset_n  asynchronous active-low reset
//   bus      pixel_layer_scheduler_if.slave (request, ROM port, result)
// Optional feature macro: LAYER_SKIP_EN
//   defined   : ineligible layers are skipped and the walk stops at the first
//               hit (latency 3..11 cycles)
//   undefined : all five layers are fetched every pixel (latency 11 cycles)
// -----------------------------------------------------------------------------
module pixel_layer_scheduler #(
    parameter int ROM_AW = 17,
    parameter int IDX_W  = 4
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    pixel_layer_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, CHECK, DONE} state_t;

    state_t            state_r;
    logic [2:0]        layer_r;
    logic [9:0]        dx_r, dy_r, bx_r, by_r, ux_r, uy_r;
    logic              ball_r, duck_r;
    logic [3:0]        lives_r;
    logic              pix_ready_r, out_valid_r;
    logic [IDX_W-1:0]  out_idx_r;
    logic [2:0]        out_layer_r;
    logic [ROM_AW-1:0] rom_addr_r;
    logic [2:0]        rom_layer_r;
`ifndef LAYER_SKIP_EN
    logic              win_found_r;
    logic [IDX_W-1:0]  win_idx_r;
    logic [2:0]        win_layer_r;
`endif

    logic [9:0]        src_dx_s, src_dy_s, src_bx_s, src_by_s, src_ux_s, src_uy_s;
    logic              src_ball_s, src_duck_s;
    logic [3:0]        src_lives_s;
    logic [10:0]       dist_x_s, dist_y_s, lives_lim_s;
    logic [7:0]        elig_s;
    logic [2:0]        start_s, nxt_s;
    logic [ROM_AW-1:0] nxt_addr_s;
    logic              data_nz_s;

    // The first fetch is launched on the accept edge, so in IDLE the addresses
    // come straight from the request; afterwards from the captured copy.
    always_comb begin
        if (state_r == IDLE) begin
            src_dx_s    = bus.DrawX;
            src_dy_s    = bus.DrawY;
            src_bx_s    = bus.Ball_Draw_X;
            src_by_s    = bus.Ball_Draw_Y;
            src_ux_s    = bus.Duck_Draw_X;
            src_uy_s    = bus.Duck_Draw_Y;
            src_ball_s  = bus.is_ball;
            src_duck_s  = bus.is_duck;
            src_lives_s = bus.lives;
        end else begin
            src_dx_s    = dx_r;
            src_dy_s    = dy_r;
            src_bx_s    = bx_r;
            src_by_s    = by_r;
            src_ux_s    = ux_r;
            src_uy_s    = uy_r;
            src_ball_s  = ball_r;
            src_duck_s  = duck_r;
            src_lives_s = lives_r;
        end
    end

    // Layer eligibility; the lives banner window grows by 31 pixels per life.
    always_comb begin
        dist_x_s    = {1'b0, src_dx_s} - 11'd20;
        dist_y_s    = {1'b0, src_dy_s} - 11'd430;
        lives_lim_s = 11'd55 + 11'd31 * {7'd0, src_lives_s};
        elig_s      = 8'd0;
        elig_s[0]   = !dist_x_s[10] && (dist_x_s <= lives_lim_s) &&
                      !dist_y_s[10] && (dist_y_s <= 11'd27);
        elig_s[1]   = src_ball_s;
        elig_s[2]   = 1'b1;
        elig_s[3]   = src_duck_s;
        elig_s[4]   = 1'b1;
    end

    // Next layer to fetch: from IDLE start at LIVES, otherwise after the current one.
    always_comb begin
        if (state_r == IDLE) begin
            start_s = 3'd0;
        end else begin
            start_s = 3'(layer_r + 3'd1);
        end
`ifdef LAYER_SKIP_EN
        // Descending scan leaves the lowest eligible layer >= start; BACK always qualifies.
        nxt_s = 3'd4;
        for (int i = 4; i >= 0; i--) begin
            if ((3'(i) >= start_s) && elig_s[i]) begin
                nxt_s = 3'(i);
            end else begin
                nxt_s = nxt_s;
            end
        end
`else
        nxt_s = start_s;
`endif
    end

    // ROM address of the next layer to fetch.
    always_comb begin
        case (nxt_s)
            3'd0:    nxt_addr_s = ROM_AW'(dist_x_s) + ROM_AW'(dist_y_s) * ROM_AW'(8'd210);
            3'd1:    nxt_addr_s = ROM_AW'(src_bx_s) + ROM_AW'(src_by_s) * ROM_AW'(6'd60);
            3'd3:    nxt_addr_s = ROM_AW'(src_ux_s) + ROM_AW'(src_uy_s) * ROM_AW'(7'd80);
            default: nxt_addr_s = ROM_AW'(src_dx_s[9:1]) + ROM_AW'(src_dy_s[9:1]) * ROM_AW'(9'd320);
        endcase
        data_nz_s = (bus.rom_data != {IDX_W{1'b0}});
    end

    // Scheduler FSM with registered handshake, ROM and result outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= IDLE;
            layer_r     <= 3'd0;
            dx_r        <= 10'd0;
            dy_r        <= 10'd0;
            bx_r        <= 10'd0;
            by_r        <= 10'd0;
            ux_r        <= 10'd0;
            uy_r        <= 10'd0;
            ball_r      <= 1'b0;
            duck_r      <= 1'b0;
            lives_r     <= 4'd0;
            pix_ready_r <= 1'b1;
            out_valid_r <= 1'b0;
            out_idx_r   <= {IDX_W{1'b0}};
            out_layer_r <= 3'd0;
            rom_addr_r  <= {ROM_AW{1'b0}};
            rom_layer_r <= 3'd0;
`ifndef LAYER_SKIP_EN
            win_found_r <= 1'b0;
            win_idx_r   <= {IDX_W{1'b0}};
            win_layer_r <= 3'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.pix_valid) begin
                        dx_r        <= bus.DrawX;
                        dy_r        <= bus.DrawY;
                        bx_r        <= bus.Ball_Draw_X;
                        by_r        <= bus.Ball_Draw_Y;
                        ux_r        <= bus.Duck_Draw_X;
                        uy_r        <= bus.Duck_Draw_Y;
                        ball_r      <= bus.is_ball;
                        duck_r      <= bus.is_duck;
                        lives_r     <= bus.lives;
                        layer_r     <= nxt_s;
                        rom_addr_r  <= nxt_addr_s;
                        rom_layer_r <= nxt_s;
                        pix_ready_r <= 1'b0;
`ifndef LAYER_SKIP_EN
                        win_found_r <= 1'b0;
`endif
                        state_r     <= FETCH;
                    end
                end
                FETCH: begin
                    state_r <= CHECK;
                end
                CHECK: begin
`ifdef LAYER_SKIP_EN
                    if (data_nz_s || (layer_r == 3'd4)) begin
                        out_idx_r   <= bus.rom_data;
                        out_layer_r <= layer_r;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        layer_r     <= nxt_s;
                        rom_addr_r  <= nxt_addr_s;
                        rom_layer_r <= nxt_s;
                        state_r     <= FETCH;
                    end
`else
                    if (layer_r == 3'd4) begin
                        // BACK is last: an earlier winner beats it, else BACK data (possibly 0).
                        if (win_found_r) begin
                            out_idx_r   <= win_idx_r;
                            out_layer_r <= win_layer_r;
                        end else begin
                            out_idx_r   <= bus.rom_data;
                            out_layer_r <= 3'd4;
                        end
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        if (!win_found_r && elig_s[layer_r] && data_nz_s) begin
                            win_found_r <= 1'b1;
                            win_idx_r   <= bus.rom_data;
                            win_layer_r <= layer_r;
                        end
                        layer_r     <= nxt_s;
                        rom_addr_r  <= nxt_addr_s;
                        rom_layer_r <= nxt_s;
                        state_r     <= FETCH;
                    end
`endif
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        pix_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    pix_ready_r <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pix_ready = pix_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_layer = out_layer_r;
    assign bus.rom_addr  = rom_addr_r;
    assign bus.rom_layer = rom_layer_r;

endmodule
